// File: rtl/alu_operand_stage.sv
// Purpose : ID/EX pipeline register feeding the ALU; resolves EX/MEM and MEM/WB forwarding before latching.
// Latency : 1 cycle from decode inputs to ALU-facing outputs; every output comes straight from a flop.
// Backpressure: stall holds the stage and refreshes held operands from retiring producers; flush squashes it.
//
// Ports:
//   clk, reset           - rising-edge clock, synchronous active-high reset
//   stall, flush         - hazard-unit hold / branch squash (flush wins)
//   in_*                 - decoded instruction: operands, indices, immediate, opcode, carry-in, destination
//   exmem_*, memwb_*     - forwarding sources (qualifiers, destination index, result data)
//   out_*                - registered ALU inputs and downstream destination info
//   fwd_count, stall_count - statistics, live only when ALU_OPERAND_STATS_EN is defined (else tied to 0)
module alu_operand_stage #(
    parameter int DATA_W = 16,
    parameter int RIDX_W = 2,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [RIDX_W-1:0] in_rs_idx,
    input  logic [RIDX_W-1:0] in_rt_idx,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic [OP_W-1:0]   in_op,
    input  logic              in_cin,
    input  logic [RIDX_W-1:0] in_rd_idx,
    input  logic              in_reg_write,
    input  logic              exmem_valid,
    input  logic              exmem_reg_write,
    input  logic [RIDX_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_valid,
    input  logic              memwb_reg_write,
    input  logic [RIDX_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [OP_W-1:0]   out_op,
    output logic              out_cin,
    output logic [RIDX_W-1:0] out_rd_idx,
    output logic              out_reg_write,
    output logic [15:0]       fwd_count,
    output logic [15:0]       stall_count
);

    // Source indices and immediate select of the instruction currently held,
    // needed to keep refreshing its operands while stalled.
    logic [RIDX_W-1:0] rs_idx_q;
    logic [RIDX_W-1:0] rt_idx_q;
    logic              use_imm_q;

    // One forwarding network serves both load and stall-refresh: during a
    // stall the index comes from the held copy and the fallback value is the
    // operand already in the output register.
    logic [RIDX_W-1:0] a_idx, b_idx;
    logic [DATA_W-1:0] a_base, b_base;
    logic [DATA_W-1:0] a_fwd, b_fwd;
    logic              a_ex, a_mw, b_ex, b_mw;
    logic              a_hit, b_hit;
    logic              b_imm;

    always_comb begin
        a_idx  = stall ? rs_idx_q  : in_rs_idx;
        b_idx  = stall ? rt_idx_q  : in_rt_idx;
        a_base = stall ? out_a     : in_rs_data;
        b_base = stall ? out_b     : in_rt_data;
        b_imm  = stall ? use_imm_q : in_use_imm;

        a_ex = exmem_valid & exmem_reg_write & (exmem_rd == a_idx);
        a_mw = memwb_valid & memwb_reg_write & (memwb_rd == a_idx);
        b_ex = exmem_valid & exmem_reg_write & (exmem_rd == b_idx);
        b_mw = memwb_valid & memwb_reg_write & (memwb_rd == b_idx);

        // EX/MEM is the younger producer, so it takes priority.
        a_fwd = a_ex ? exmem_data : (a_mw ? memwb_data : a_base);
        b_fwd = b_ex ? exmem_data : (b_mw ? memwb_data : b_base);

        a_hit = a_ex | a_mw;
        // An immediate B operand never takes a forwarded value.
        b_hit = (b_ex | b_mw) & ~b_imm;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_a         <= '0;
            out_b         <= '0;
            out_op        <= '0;
            out_cin       <= 1'b0;
            out_rd_idx    <= '0;
            out_reg_write <= 1'b0;
            rs_idx_q      <= '0;
            rt_idx_q      <= '0;
            use_imm_q     <= 1'b0;
        end else if (flush) begin
            // Squash: only the qualifiers matter; op cleared to a benign value.
            out_valid     <= 1'b0;
            out_reg_write <= 1'b0;
            out_op        <= '0;
        end else if (stall) begin
            // Hold everything, but let a producer retiring mid-stall update
            // the held operands so the ALU never sees a stale value.
            if (out_valid) begin
                out_a <= a_fwd;
                if (!use_imm_q) begin
                    out_b <= b_fwd;
                end
            end
        end else begin
            out_valid     <= in_valid;
            out_reg_write <= in_valid & in_reg_write;
            out_a         <= a_fwd;
            out_b         <= in_use_imm ? in_imm : b_fwd;
            out_op        <= in_op;
            out_cin       <= in_cin;
            out_rd_idx    <= in_rd_idx;
            rs_idx_q      <= in_rs_idx;
            rt_idx_q      <= in_rt_idx;
            use_imm_q     <= in_use_imm;
        end
    end

`ifdef ALU_OPERAND_STATS_EN
    logic [15:0] fwd_count_q;
    logic [15:0] stall_count_q;
    logic [1:0]  fwd_inc;
    logic [16:0] fwd_sum;
    logic        fwd_active;

    always_comb begin
        // Forwarding is counted on a load, or on a refresh of a valid held instruction.
        fwd_active = ~flush & (~stall | out_valid);
        fwd_inc    = '0;
        if (fwd_active) begin
            fwd_inc = {1'b0, a_hit} + {1'b0, b_hit};
        end
        fwd_sum = {1'b0, fwd_count_q} + {15'b0, fwd_inc};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            // Saturate rather than wrap.
            fwd_count_q <= fwd_sum[16] ? 16'hFFFF : fwd_sum[15:0];
            if (stall && !flush && out_valid && (stall_count_q != 16'hFFFF)) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
        end
    end

    assign fwd_count   = fwd_count_q;
    assign stall_count = stall_count_q;
`else
    assign fwd_count   = 16'h0000;
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid;
    logic [15:0] in_rs_data, in_rt_data, in_imm;
    logic [1:0]  in_rs_idx, in_rt_idx, in_rd_idx;
    logic        in_use_imm, in_cin, in_reg_write;
    logic [3:0]  in_op;
    logic        exmem_valid, exmem_reg_write, memwb_valid, memwb_reg_write;
    logic [1:0]  exmem_rd, memwb_rd;
    logic [15:0] exmem_data, memwb_data;
    logic        out_valid, out_cin, out_reg_write;
    logic [15:0] out_a, out_b, fwd_count, stall_count;
    logic [3:0]  out_op;
    logic [1:0]  out_rd_idx;

    int n_cmp = 0;
    int n_bad = 0;

    alu_operand_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_op(in_op), .in_cin(in_cin),
        .in_rd_idx(in_rd_idx), .in_reg_write(in_reg_write),
        .exmem_valid(exmem_valid), .exmem_reg_write(exmem_reg_write),
        .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_valid(memwb_valid), .memwb_reg_write(memwb_reg_write),
        .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_op(out_op),
        .out_cin(out_cin), .out_rd_idx(out_rd_idx), .out_reg_write(out_reg_write),
        .fwd_count(fwd_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Reference model: architectural view of the stage contents.
    bit          m_valid, m_rw, m_cin, m_imm;
    logic [15:0] m_a, m_b;
    logic [3:0]  m_op;
    logic [1:0]  m_rd, m_rs, m_rt;
    int          m_fc, m_sc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Value an operand read of register idx should see given the live producers.
    function automatic logic [15:0] m_fwd(input logic [1:0] idx, input logic [15:0] rf, output bit hit);
        hit = 1'b1;
        if (exmem_valid && exmem_reg_write && exmem_rd == idx) return exmem_data;
        if (memwb_valid && memwb_reg_write && memwb_rd == idx) return memwb_data;
        hit = 1'b0;
        return rf;
    endfunction

    task automatic bump_fwd(input bit h);
`ifdef ALU_OPERAND_STATS_EN
        if (h && m_fc < 65535) m_fc++;
`endif
    endtask

    task automatic model_step();
        bit h;
        if (reset) begin
            m_valid = 0; m_rw = 0; m_cin = 0; m_imm = 0;
            m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_rs = 0; m_rt = 0;
            m_fc = 0; m_sc = 0;
        end else if (flush) begin
            m_valid = 0; m_rw = 0; m_op = 0;
        end else if (stall) begin
            if (m_valid) begin
                m_a = m_fwd(m_rs, m_a, h); bump_fwd(h);
                if (!m_imm) begin
                    m_b = m_fwd(m_rt, m_b, h); bump_fwd(h);
                end
`ifdef ALU_OPERAND_STATS_EN
                if (m_sc < 65535) m_sc++;
`endif
            end
        end else begin
            m_valid = in_valid;
            m_rw    = in_valid && in_reg_write;
            m_a     = m_fwd(in_rs_idx, in_rs_data, h); bump_fwd(h);
            if (in_use_imm) m_b = in_imm;
            else begin
                m_b = m_fwd(in_rt_idx, in_rt_data, h); bump_fwd(h);
            end
            m_op = in_op; m_cin = in_cin; m_rd = in_rd_idx;
            m_rs = in_rs_idx; m_rt = in_rt_idx; m_imm = in_use_imm;
        end
    endtask

    task automatic check_outputs();
        chk("valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("reg_write", {31'b0, out_reg_write}, {31'b0, m_rw});
        if (m_valid) begin
            chk("a", {16'b0, out_a}, {16'b0, m_a});
            chk("b", {16'b0, out_b}, {16'b0, m_b});
            chk("op", {28'b0, out_op}, {28'b0, m_op});
            chk("cin", {31'b0, out_cin}, {31'b0, m_cin});
            chk("rd", {30'b0, out_rd_idx}, {30'b0, m_rd});
        end
        chk("fwd_count", {16'b0, fwd_count}, m_fc);
        chk("stall_count", {16'b0, stall_count}, m_sc);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked there too.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        reset = 0; stall = 0; flush = 0; in_valid = 0;
        in_rs_data = 0; in_rt_data = 0; in_imm = 0; in_rs_idx = 0; in_rt_idx = 0;
        in_rd_idx = 0; in_use_imm = 0; in_cin = 0; in_reg_write = 0; in_op = 0;
        exmem_valid = 0; exmem_reg_write = 0; exmem_rd = 0; exmem_data = 0;
        memwb_valid = 0; memwb_reg_write = 0; memwb_rd = 0; memwb_data = 0;
    endtask

    initial begin
        idle();
        m_fc = 0; m_sc = 0;

        // Reset state
        reset = 1;
        cyc(); cyc();
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_a", {16'b0, out_a}, 32'd0);
        chk("rst_b", {16'b0, out_b}, 32'd0);
        chk("rst_op_cin_rd_rw", {24'b0, out_op, out_cin, out_rd_idx, out_reg_write}, 32'd0);
        chk("rst_counts", {fwd_count, stall_count}, 32'd0);
        reset = 0;

        // EX/MEM beats MEM/WB, then MEM/WB alone
        in_valid = 1; in_reg_write = 1; in_rs_idx = 1; in_rs_data = 16'h0003;
        exmem_valid = 1; exmem_reg_write = 1; exmem_rd = 1; exmem_data = 16'h00AA;
        memwb_valid = 1; memwb_reg_write = 1; memwb_rd = 1; memwb_data = 16'h00BB;
        cyc();
        chk("exmem_prio", {16'b0, out_a}, 32'h00AA);
        exmem_valid = 0;
        cyc();
        chk("memwb_fwd", {16'b0, out_a}, 32'h00BB);

        // Immediate is never forwarded
        idle();
        in_valid = 1; in_use_imm = 1; in_imm = 16'h0012; in_rt_idx = 2;
        in_rt_data = 16'h5555; in_op = 4'd9; in_cin = 1;
        exmem_valid = 1; exmem_reg_write = 1; exmem_rd = 2; exmem_data = 16'hFFFF;
        cyc();
        chk("imm_b", {16'b0, out_b}, 32'h0012);
        chk("imm_op", {28'b0, out_op}, 32'd9);
        chk("imm_cin", {31'b0, out_cin}, 32'd1);

        // Producer retiring during a 3-cycle stall is captured
        idle();
        reset = 1; cyc(); reset = 0;
        in_valid = 1; in_rs_idx = 3; in_rs_data = 16'h0001; in_rt_idx = 0;
        cyc();
        chk("stall_load_a", {16'b0, out_a}, 32'h0001);
        in_valid = 0; in_rs_data = 16'h7777; stall = 1;
        cyc();
        chk("stall_c1_a", {16'b0, out_a}, 32'h0001);
        memwb_valid = 1; memwb_reg_write = 1; memwb_rd = 3; memwb_data = 16'h1234;
        cyc();
        chk("stall_c2_a", {16'b0, out_a}, 32'h1234);
        memwb_valid = 0;
        cyc();
        chk("stall_c3_a", {16'b0, out_a}, 32'h1234);
        chk("stall_c3_valid", {31'b0, out_valid}, 32'd1);
`ifdef ALU_OPERAND_STATS_EN
        chk("stall_cnt3", {16'b0, stall_count}, 32'd3);
        chk("fwd_cnt1", {16'b0, fwd_count}, 32'd1);
`else
        chk("stall_cnt_off", {16'b0, stall_count}, 32'd0);
        chk("fwd_cnt_off", {16'b0, fwd_count}, 32'd0);
`endif

        // Flush beats stall, then a clean load
        idle();
        in_valid = 1; in_reg_write = 1; cyc();
        stall = 1; flush = 1; in_valid = 0;
        cyc();
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_rw", {31'b0, out_reg_write}, 32'd0);
        stall = 0; flush = 0; in_valid = 1; in_reg_write = 1; in_rs_data = 16'hBEEF; in_rs_idx = 2;
        cyc();
        chk("post_flush_valid", {31'b0, out_valid}, 32'd1);
        chk("post_flush_a", {16'b0, out_a}, 32'hBEEF);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            in_valid = $urandom_range(0, 1); in_reg_write = $urandom_range(0, 1);
            in_rs_data = 16'($urandom); in_rt_data = 16'($urandom); in_imm = 16'($urandom);
            in_rs_idx = 2'($urandom); in_rt_idx = 2'($urandom); in_rd_idx = 2'($urandom);
            in_use_imm = $urandom_range(0, 1); in_cin = $urandom_range(0, 1); in_op = 4'($urandom);
            exmem_valid = ($urandom_range(0, 3) != 0); exmem_reg_write = $urandom_range(0, 1);
            exmem_rd = 2'($urandom); exmem_data = 16'($urandom);
            memwb_valid = ($urandom_range(0, 3) != 0); memwb_reg_write = $urandom_range(0, 1);
            memwb_rd = 2'($urandom); memwb_data = 16'($urandom);
            cyc();
        end

`ifdef ALU_OPERAND_STATS_EN
        // Stall counter saturation
        idle();
        reset = 1; cyc(); reset = 0;
        in_valid = 1; cyc();
        in_valid = 0; stall = 1;
        for (int i = 0; i < 70000; i++) cyc();
        chk("stall_sat", {16'b0, stall_count}, 32'hFFFF);
        for (int i = 0; i < 4; i++) cyc();
        chk("stall_sat_hold", {16'b0, stall_count}, 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
